// File: rtl/mtc2sl_pkg.sv
// Shared definitions for the MTC-to-Sector-Logic receive path: candidate
// word geometry, BCID range and the BCID-tagged candidate type.
package mtc2sl_pkg;

  localparam int MTC2SL_LEN     = 193;
  localparam int MTC2SL_VLD_BIT = MTC2SL_LEN - 1;
  localparam int N_SLOTS        = 2;
  localparam int BCID_W         = 12;
  localparam int CNT_W          = 16;

  localparam logic [BCID_W-1:0] BX_MAX = 12'd3563;

  typedef struct packed {
    logic [MTC2SL_LEN-1:0] word;
    logic [BCID_W-1:0]     bcid;
  } mtc2sl_tag_t;

endpackage

// File: rtl/mtc2sl_fifo_2w1r.sv
// Show-ahead FIFO accepting up to two writes and one read per cycle.
// The caller guarantees wr_cnt never exceeds the free space.
module mtc2sl_fifo_2w1r
  import mtc2sl_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int OW         = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        wr_cnt,
  input  mtc2sl_tag_t       wr_data0,
  input  mtc2sl_tag_t       wr_data1,
  input  logic              rd_en,
  output mtc2sl_tag_t       rd_data,
  output logic [OW-1:0]     occ,
  output logic              not_empty
);

  mtc2sl_tag_t   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          pop;

  assign not_empty = (occ != '0);
  assign pop       = rd_en & not_empty;
  // Head is forced to zero when empty so stale entries never leak out.
  assign rd_data   = not_empty ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_cnt);
      rd_ptr <= rd_ptr + AW'(pop);
      occ    <= occ + OW'(wr_cnt) - OW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_cnt != 2'd0) mem[wr_ptr] <= wr_data0;
    if (wr_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= wr_data1;
  end

endmodule

// File: rtl/mtc2sl_rx.sv
// MTC2SL receive unpacker: captures both slots on each BX strobe, tags valid
// candidates with the BCID and buffers them for a valid/ready consumer.
module mtc2sl_rx
  import mtc2sl_pkg::*;
#(
  parameter  int FIFO_DEPTH = 8,
  localparam int OW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bx,
  input  logic                          i_bcr,
  input  logic [MTC2SL_LEN*N_SLOTS-1:0] mtc_i,
  output logic [MTC2SL_LEN-1:0]         o_mtc,
  output logic [BCID_W-1:0]             o_bcid,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic [CNT_W-1:0]              o_accept_cnt,
  output logic [CNT_W-1:0]              o_drop_cnt,
  output logic                          o_overflow
);

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  logic [BCID_W-1:0]     bcid_cnt;
  logic [BCID_W-1:0]     bcid_tag;
  logic [MTC2SL_LEN-1:0] slot_p0 [N_SLOTS];
  logic [BCID_W-1:0]     tag_p0;
  logic [N_SLOTS-1:0]    vld_p0;

  logic [1:0]            k_p0;
  logic [OW-1:0]         free_p0;
  logic [1:0]            wr_cnt_p0;
  logic [1:0]            drop_p0;
  mtc2sl_tag_t           wr_data0_p0;
  mtc2sl_tag_t           wr_data1_p0;
  mtc2sl_tag_t           head;
  logic [OW-1:0]         occ;

  // A BX coinciding with BCR is tagged 0 and the counter resumes at 1.
  assign bcid_tag = i_bcr ? '0 : bcid_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      bcid_cnt <= '0;
    end else if (i_bcr) begin
      bcid_cnt <= bx ? BCID_W'(1) : '0;
    end else if (bx) begin
      bcid_cnt <= (bcid_cnt == BX_MAX) ? '0 : bcid_cnt + BCID_W'(1);
    end
  end

  // ---- Stage p0: capture both slots on the BX strobe ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
    end else begin
      for (int s = 0; s < N_SLOTS; s++)
        vld_p0[s] <= bx & mtc_i[(N_SLOTS-1-s)*MTC2SL_LEN + MTC2SL_VLD_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (bx) begin
      for (int s = 0; s < N_SLOTS; s++)
        slot_p0[s] <= mtc_i[(N_SLOTS-s)*MTC2SL_LEN-1 -: MTC2SL_LEN];
      tag_p0 <= bcid_tag;
    end
  end

  // ---- Write stage: compact valid slots and clip to free space ----
  always_comb begin
    k_p0      = {1'b0, vld_p0[0]} + {1'b0, vld_p0[1]};
    free_p0   = OW'(FIFO_DEPTH) - occ;
    wr_cnt_p0 = k_p0;
    if (OW'(k_p0) > free_p0) wr_cnt_p0 = free_p0[1:0];
    drop_p0   = k_p0 - wr_cnt_p0;
    wr_data0_p0.word = vld_p0[0] ? slot_p0[0] : slot_p0[1];
    wr_data0_p0.bcid = tag_p0;
    wr_data1_p0.word = slot_p0[1];
    wr_data1_p0.bcid = tag_p0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_accept_cnt <= '0;
      o_drop_cnt   <= '0;
      o_overflow   <= 1'b0;
    end else begin
      o_accept_cnt <= sat_add(o_accept_cnt, wr_cnt_p0);
      o_drop_cnt   <= sat_add(o_drop_cnt, drop_p0);
      if (drop_p0 != 2'd0) o_overflow <= 1'b1;
    end
  end

  mtc2sl_fifo_2w1r #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_cnt    (wr_cnt_p0),
    .wr_data0  (wr_data0_p0),
    .wr_data1  (wr_data1_p0),
    .rd_en     (i_ready),
    .rd_data   (head),
    .occ       (occ),
    .not_empty (o_valid)
  );

  assign o_mtc  = head.word;
  assign o_bcid = head.bcid;

endmodule

// File: tb/tb_mtc2sl_rx.sv
// Bench for mtc2sl_rx: cycle-level scoreboard model plus directed scenarios
// for latency, slot ordering, overflow, edge-of-full, BCID wrap and reset.
module tb_mtc2sl_rx;
  import mtc2sl_pkg::*;

  localparam int L     = MTC2SL_LEN;
  localparam int DEPTH = 8;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic                  bx = 1'b0;
  logic                  i_bcr = 1'b0;
  logic                  i_ready = 1'b0;
  logic [L*N_SLOTS-1:0]  mtc_i = '0;
  logic [L-1:0]          o_mtc;
  logic [BCID_W-1:0]     o_bcid;
  logic                  o_valid;
  logic [CNT_W-1:0]      o_accept_cnt;
  logic [CNT_W-1:0]      o_drop_cnt;
  logic                  o_overflow;

  int n_chk  = 0;
  int n_fail = 0;
  int n_pop  = 0;
  logic [BCID_W-1:0] last_bcid = '0;

  mtc2sl_tag_t q[$];
  logic              rst_prev = 1'b1;
  logic [1:0]        cap_v = '0;
  logic [L-1:0]      cap_w [2];
  logic [BCID_W-1:0] cap_tag = '0;
  logic [BCID_W-1:0] m_cnt = '0;
  logic [15:0]       m_acc = '0;
  logic [15:0]       m_drop = '0;
  logic              m_ovf = 1'b0;

  always #5 clk = ~clk;

  mtc2sl_rx #(.FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .bx           (bx),
    .i_bcr        (i_bcr),
    .mtc_i        (mtc_i),
    .o_mtc        (o_mtc),
    .o_bcid       (o_bcid),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_accept_cnt (o_accept_cnt),
    .o_drop_cnt   (o_drop_cnt),
    .o_overflow   (o_overflow)
  );

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [15:0] sat1(input logic [15:0] a);
    return (a == 16'hFFFF) ? a : a + 16'd1;
  endfunction

  function automatic logic [L-1:0] mkw(input logic vld);
    logic [223:0] r;
    logic [L-1:0] w;
    r = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom()};
    w = r[L-1:0];
    w[L-1] = vld;
    return w;
  endfunction

  // Reference model: checks the DUT state, applies the pending write stage,
  // retires a pop, then samples this cycle's inputs for the next write.
  always @(negedge clk) begin
    int          free;
    logic        pop;
    mtc2sl_tag_t e;
    if (rst_prev) begin
      q.delete();
      m_acc  = '0;
      m_drop = '0;
      m_ovf  = 1'b0;
    end
    chk("o_valid", o_valid, q.size() != 0);
    chk("accept_cnt", o_accept_cnt, m_acc);
    chk("drop_cnt", o_drop_cnt, m_drop);
    chk("overflow", o_overflow, m_ovf);
    pop = 1'b0;
    if (o_valid && q.size() != 0) begin
      chk("head_word", o_mtc, q[0].word);
      chk("head_bcid", o_bcid, q[0].bcid);
      pop = i_ready;
    end
    free = DEPTH - q.size();
    for (int s = 0; s < 2; s++) begin
      if (cap_v[s]) begin
        if (free > 0) begin
          e.word = cap_w[s];
          e.bcid = cap_tag;
          q.push_back(e);
          free--;
          m_acc = sat1(m_acc);
        end else begin
          m_drop = sat1(m_drop);
          m_ovf  = 1'b1;
        end
      end
    end
    if (pop) begin
      last_bcid = q[0].bcid;
      void'(q.pop_front());
      n_pop++;
    end
    rst_prev = rst;
    if (rst) begin
      cap_v = '0;
      m_cnt = '0;
    end else begin
      if (i_bcr) begin
        cap_tag = '0;
        m_cnt   = bx ? 12'd1 : 12'd0;
      end else begin
        cap_tag = m_cnt;
        if (bx) m_cnt = (m_cnt == 12'd3563) ? 12'd0 : m_cnt + 12'd1;
      end
      cap_w[0] = mtc_i[2*L-1:L];
      cap_w[1] = mtc_i[L-1:0];
      cap_v    = bx ? {mtc_i[L-1], mtc_i[2*L-1]} : 2'b00;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bx_cycle(input logic [L-1:0] s0, input logic [L-1:0] s1, input logic bcr);
    bx    = 1'b1;
    i_bcr = bcr;
    mtc_i = {s0, s1};
    @(posedge clk);
    #1;
    bx    = 1'b0;
    i_bcr = 1'b0;
    mtc_i = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [L-1:0] wa, wb;
    int p0, p1;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_mtc", o_mtc, '0);
    chk("rst_bcid", o_bcid, '0);
    chk("rst_acc", o_accept_cnt, '0);
    chk("rst_drop", o_drop_cnt, '0);
    chk("rst_ovf", o_overflow, 1'b0);

    // single candidate, latency and BCID 3
    i_ready = 1'b1;
    i_bcr = 1'b1;
    idle(1);
    i_bcr = 1'b0;
    repeat (3) bx_cycle(mkw(0), mkw(0), 1'b0);
    wa = {1'b1, {(L-9){1'b0}}, 8'hA5};
    bx_cycle(wa, mkw(0), 1'b0);
    chk("lat_n1_valid", o_valid, 1'b0);
    idle(1);
    chk("lat_n2_valid", o_valid, 1'b1);
    chk("lat_word", o_mtc, wa);
    chk("lat_bcid", o_bcid, 12'd3);
    idle(1);
    chk("single_gone", o_valid, 1'b0);
    chk("single_acc", o_accept_cnt, 16'd1);

    // slot ordering: both valid, then slot 1 only
    wa = mkw(1);
    wb = mkw(1);
    bx_cycle(wa, wb, 1'b0);
    idle(1);
    chk("order_first", o_mtc, wa);
    chk("order_bcid0", o_bcid, 12'd4);
    idle(1);
    chk("order_second", o_mtc, wb);
    chk("order_bcid1", o_bcid, 12'd4);
    idle(2);
    wb = mkw(1);
    bx_cycle(mkw(0), wb, 1'b0);
    idle(1);
    chk("slot1_only", o_mtc, wb);
    idle(1);
    chk("slot1_single", o_valid, 1'b0);

    // random mix with back-pressure
    for (int i = 0; i < 24; i++) begin
      bx_cycle(mkw(1'($urandom_range(0, 1))), mkw(1'($urandom_range(0, 1))), 1'b0);
      i_ready = 1'($urandom_range(0, 1));
      idle(1);
    end
    i_ready = 1'b1;
    idle(20);

    // overflow: 10 valid candidates into 8 entries
    do_reset();
    i_ready = 1'b0;
    p0 = n_pop;
    for (int i = 0; i < 5; i++) begin
      bx_cycle(mkw(1), mkw(1), 1'b0);
      idle(1);
    end
    idle(2);
    chk("ovf_drop", o_drop_cnt, 16'd2);
    chk("ovf_flag", o_overflow, 1'b1);
    chk("ovf_acc", o_accept_cnt, 16'd8);
    i_ready = 1'b1;
    idle(12);
    chk("ovf_drained", n_pop - p0, 8);
    chk("ovf_empty", o_valid, 1'b0);

    // edge of full: occupancy 7, two valid with a coincident pop
    do_reset();
    i_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bx_cycle(mkw(1), mkw(1), 1'b0);
      idle(1);
    end
    bx_cycle(mkw(1), mkw(0), 1'b0);
    idle(2);
    p0 = n_pop;
    bx_cycle(mkw(1), mkw(1), 1'b0);
    i_ready = 1'b1;
    idle(1);
    i_ready = 1'b0;
    idle(2);
    p1 = n_pop;
    chk("edge_one_pop", p1 - p0, 1);
    chk("edge_drop", o_drop_cnt, 16'd1);
    chk("edge_acc", o_accept_cnt, 16'd8);
    chk("edge_ovf", o_overflow, 1'b1);
    i_ready = 1'b1;
    idle(12);
    chk("edge_occ7", n_pop - p1, 7);

    // BCID wrap and BCR coincident with BX
    do_reset();
    i_bcr = 1'b1;
    idle(1);
    i_bcr = 1'b0;
    repeat (3563) bx_cycle(mkw(0), mkw(0), 1'b0);
    bx_cycle(mkw(1), mkw(0), 1'b0);
    idle(2);
    chk("wrap_max", last_bcid, 12'd3563);
    bx_cycle(mkw(1), mkw(0), 1'b0);
    idle(2);
    chk("wrap_zero", last_bcid, 12'd0);
    bx_cycle(mkw(1), mkw(0), 1'b1);
    idle(2);
    chk("bcr_tag", last_bcid, 12'd0);
    bx_cycle(mkw(1), mkw(0), 1'b0);
    idle(2);
    chk("bcr_next", last_bcid, 12'd1);

    // reset with 5 entries held and a capture pending
    i_ready = 1'b0;
    bx_cycle(mkw(1), mkw(1), 1'b0);
    idle(1);
    bx_cycle(mkw(1), mkw(1), 1'b0);
    idle(1);
    bx_cycle(mkw(1), mkw(0), 1'b0);
    idle(2);
    bx_cycle(mkw(1), mkw(1), 1'b0);
    do_reset();
    chk("mid_rst_valid", o_valid, 1'b0);
    chk("mid_rst_acc", o_accept_cnt, 16'd0);
    chk("mid_rst_drop", o_drop_cnt, 16'd0);
    chk("mid_rst_ovf", o_overflow, 1'b0);
    p0 = n_pop;
    i_ready = 1'b1;
    idle(8);
    chk("no_stale", n_pop - p0, 0);
    chk("no_stale_valid", o_valid, 1'b0);
    chk("sb_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
